// File: rtl/gcd_pkg.sv
// Types and constants shared between the GCD stage and its consumers.
package gcd_pkg;
    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_NUM = 2'd1,
        DIV_DEN = 2'd2,
        DONE    = 2'd3
    } state_t;
endpackage

// File: rtl/restoring_div_step.sv
// One combinational iteration of an MSB-first restoring divider.
module restoring_div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // The shifted partial remainder needs one extra bit; after restoring it
    // is always below the divisor and fits back into WIDTH bits.
    assign shifted  = {rem, dividend_bit};
    assign q_bit    = (shifted >= {1'b0, divisor});
    assign diff     = shifted[WIDTH-1:0] - divisor;
    assign rem_next = q_bit ? diff : shifted[WIDTH-1:0];
endmodule

// File: rtl/fraction_reduce.sv
// Divides a numerator/denominator pair by their GCD using one shared divider.
// Optional build macro FRACTION_REDUCE_REMCHK_EN flags a nonzero remainder in div_err.
//
// Handshake: a transfer happens on any rising edge where valid and ready are
// both high; valid and its payload stay stable until that edge.
module fraction_reduce
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] num_in,
    input  logic [WIDTH-1:0] den_in,
    input  logic [WIDTH-1:0] gcd_val,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] num_out,
    output logic [WIDTH-1:0] den_out,
    output logic             div_err,
    output logic             out_valid,
    input  logic             out_ready,
    output state_t           state_dbg
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] den_r;
    logic [WIDTH-1:0] gcd_r;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quotient;
    logic [CNT_W-1:0] count;
    logic             q_bit;
    logic             last_step;
`ifdef FRACTION_REDUCE_REMCHK_EN
    logic             rem_flag;
`endif

    restoring_div_step #(.WIDTH(WIDTH)) u_step (
        .rem          (rem),
        .dividend_bit (dividend[WIDTH-1]),
        .divisor      (gcd_r),
        .rem_next     (rem_next),
        .q_bit        (q_bit)
    );

    assign quotient  = {quo[WIDTH-2:0], q_bit};
    assign last_step = (count == '0);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign state_dbg = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = (gcd_val == '0) ? DONE : DIV_NUM;
            DIV_NUM: if (last_step) state_d = DIV_DEN;
            DIV_DEN: if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            den_r    <= '0;
            gcd_r    <= '0;
            dividend <= '0;
            quo      <= '0;
            rem      <= '0;
            count    <= '0;
            num_out  <= '0;
            den_out  <= '0;
            div_err  <= 1'b0;
`ifdef FRACTION_REDUCE_REMCHK_EN
            rem_flag <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        den_r <= den_in;
                        gcd_r <= gcd_val;
                        if (gcd_val == '0) begin
                            div_err <= 1'b1;
                            num_out <= num_in;
                            den_out <= den_in;
                        end else begin
                            dividend <= num_in;
                            rem      <= '0;
                            quo      <= '0;
                            count    <= CNT_W'(WIDTH - 1);
                        end
                    end
                end
                DIV_NUM, DIV_DEN: begin
                    rem      <= rem_next;
                    quo      <= quotient;
                    dividend <= {dividend[WIDTH-2:0], 1'b0};
                    count    <= count - CNT_W'(1);
                    if (last_step) begin
                        if (state_q == DIV_NUM) begin
                            // Denominator pass reuses the same divider and divisor.
                            num_out  <= quotient;
                            dividend <= den_r;
                            rem      <= '0;
                            quo      <= '0;
                            count    <= CNT_W'(WIDTH - 1);
`ifdef FRACTION_REDUCE_REMCHK_EN
                            rem_flag <= (rem_next != '0);
`endif
                        end else begin
                            den_out <= quotient;
`ifdef FRACTION_REDUCE_REMCHK_EN
                            div_err <= rem_flag | (rem_next != '0);
`endif
                        end
                    end
                end
                DONE: begin
                    if (out_ready) div_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
